// File: rtl/avmm_initiator_model.sv
// Single-outstanding Avalon-MM initiator: one cmd in, one AVMM read/write out, one rsp pulse back.
// Latency: rsp_valid at T+1 for misaligned rejects, at T+3 against a one-cycle-valid target.
// Backpressure: cmd_ready is high only in IDLE; the AVMM request is held until completion or timeout.
module avmm_initiator_model #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_response,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] avmm_addr,
  output logic              avmm_read,
  output logic              avmm_write,
  output logic [31:0]       avmm_wdata,
  output logic [3:0]        avmm_byteen,
  input  logic              avmm_rdvalid,
  input  logic              avmm_waitrq,
  input  logic              avmm_wrvalid,
  input  logic [1:0]        avmm_response,
  input  logic [31:0]       avmm_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RD_WAIT, RSP} state_t;

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;

  assign cmd_ready   = (state == IDLE);
  assign avmm_byteen = 4'hF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_response <= 2'b00;
      rsp_timeout  <= 1'b0;
      avmm_read    <= 1'b0;
      avmm_write   <= 1'b0;
      avmm_addr    <= '0;
      avmm_wdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr[1:0] != 2'b00) begin
              rsp_valid    <= 1'b1;
              rsp_rdata    <= '0;
              rsp_response <= 2'b10;
              rsp_timeout  <= 1'b0;
              state        <= RSP;
            end else begin
              avmm_addr  <= cmd_addr;
              avmm_wdata <= cmd_wdata;
              cnt        <= '0;
              if (cmd_write) begin
                avmm_write <= 1'b1;
                state      <= WRITE;
              end else begin
                avmm_read <= 1'b1;
                state     <= READ;
              end
            end
          end
        end

        WRITE, READ, RD_WAIT: begin
          // Completion is checked before the counter so it wins a same-cycle tie.
          if (state == WRITE && (!avmm_waitrq || avmm_wrvalid)) begin
            avmm_write   <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_response <= (avmm_response != 2'b00) ? 2'b01 : 2'b00;
            rsp_timeout  <= 1'b0;
            state        <= RSP;
          end else if (state != WRITE && avmm_rdvalid) begin
            avmm_read    <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= avmm_rdata;
            rsp_response <= 2'b00;
            rsp_timeout  <= 1'b0;
            state        <= RSP;
          end else if (cnt == CNT_LIMIT) begin
            avmm_read    <= 1'b0;
            avmm_write   <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_response <= 2'b11;
            rsp_timeout  <= 1'b1;
            state        <= RSP;
          end else begin
            cnt <= cnt + 16'd1;
            if (state == READ && !avmm_waitrq) begin
              avmm_read <= 1'b0;
              state     <= RD_WAIT;
            end
          end
        end

        RSP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_initiator_model.sv
// Directed bench for avmm_initiator_model against a small registered AVMM target model.
module tb_avmm_initiator_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_response;
  logic [31:0] avmm_addr, avmm_wdata, avmm_rdata;
  logic        avmm_read, avmm_write, avmm_rdvalid, avmm_waitrq, avmm_wrvalid;
  logic [3:0]  avmm_byteen;
  logic [1:0]  avmm_response;

  logic        stall, stray_rd;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  avmm_initiator_model #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_response(rsp_response),
    .rsp_timeout(rsp_timeout),
    .avmm_addr(avmm_addr), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_wdata(avmm_wdata), .avmm_byteen(avmm_byteen),
    .avmm_rdvalid(avmm_rdvalid), .avmm_waitrq(avmm_waitrq), .avmm_wrvalid(avmm_wrvalid),
    .avmm_response(avmm_response), .avmm_rdata(avmm_rdata)
  );

  // Target: 16 words at 0x00..0x3C (word i resets to i), waitrq for the first request cycle,
  // valid one cycle later; unmapped reads return 0x0BAD_0ADD, unmapped writes respond 2'b10.
  logic [31:0] mem [16];
  logic        req_q, rd_q, wr_q;
  logic [31:0] rdata_q;
  logic [1:0]  resp_q;
  wire         mapped = (avmm_addr < 32'h40);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= i;
    end else if (avmm_write && mapped) begin
      mem[avmm_addr[5:2]] <= avmm_wdata;
    end
    req_q   <= (avmm_read | avmm_write) & ~stall;
    rd_q    <= avmm_read & ~stall;
    wr_q    <= avmm_write & ~stall;
    rdata_q <= mapped ? mem[avmm_addr[5:2]] : 32'h0BAD_0ADD;
    resp_q  <= mapped ? 2'b00 : 2'b10;
  end

  assign avmm_waitrq   = stall | ~req_q;
  assign avmm_rdvalid  = rd_q | stray_rd;
  assign avmm_wrvalid  = wr_q;
  assign avmm_rdata    = rdata_q;
  assign avmm_response = resp_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one command and follow it to rsp_valid; lat is -1 if the budget expires.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int rd_cyc, output int wr_cyc,
                         output int byteen_bad);
    int waited = 0;
    lat = -1; rd_cyc = 0; wr_cyc = 0; byteen_bad = 0;
    while (!cmd_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (avmm_read)  rd_cyc++;
      if (avmm_write) wr_cyc++;
      if (avmm_byteen != 4'hF) byteen_bad++;
      if (rsp_valid) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int lat, rdc, wrc, bad, seen;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    stall = 1'b0; stray_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst cmd_ready", cmd_ready, 1);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_rdata", rsp_rdata, 0);
    check("rst rsp_response", rsp_response, 0);
    check("rst avmm_read/write", {avmm_read, avmm_write}, 0);
    check("rst avmm_addr", avmm_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: read 0x3C
    run_cmd(1'b0, 32'h3C, 32'h0, lat, rdc, wrc, bad);
    check("rd3c latency", lat, 3);
    check("rd3c rdata", rsp_rdata, 32'h0000_000F);
    check("rd3c response", rsp_response, 2'b00);
    check("rd3c read cycles", rdc, 2);
    check("rd3c byteen bad", bad, 0);

    // 2: write then read back 0x08
    run_cmd(1'b1, 32'h08, 32'hA5A5_5A5A, lat, rdc, wrc, bad);
    check("wr08 latency", lat, 3);
    check("wr08 response", rsp_response, 2'b00);
    check("wr08 write cycles", wrc, 2);
    check("wr08 rdata", rsp_rdata, 0);
    run_cmd(1'b0, 32'h08, 32'h0, lat, rdc, wrc, bad);
    check("rd08 latency", lat, 3);
    check("rd08 rdata", rsp_rdata, 32'hA5A5_5A5A);

    // 3: unmapped write / read
    run_cmd(1'b1, 32'h40, 32'h1111_2222, lat, rdc, wrc, bad);
    check("wr40 latency", lat, 3);
    check("wr40 response", rsp_response, 2'b01);
    run_cmd(1'b0, 32'h40, 32'h0, lat, rdc, wrc, bad);
    check("rd40 rdata", rsp_rdata, 32'h0BAD_0ADD);
    check("rd40 response", rsp_response, 2'b00);

    // 4: misaligned read and write
    run_cmd(1'b0, 32'h0A, 32'h0, lat, rdc, wrc, bad);
    check("mis rd latency", lat, 1);
    check("mis rd response", rsp_response, 2'b10);
    check("mis rd rdata", rsp_rdata, 0);
    check("mis rd avmm cycles", rdc + wrc, 0);
    run_cmd(1'b1, 32'h0A, 32'hDEAD_BEEF, lat, rdc, wrc, bad);
    check("mis wr latency", lat, 1);
    check("mis wr avmm cycles", rdc + wrc, 0);

    // 5: timeout with a stalled target (rdata preloaded non-zero first)
    run_cmd(1'b0, 32'h3C, 32'h0, lat, rdc, wrc, bad);
    stall = 1'b1;
    run_cmd(1'b0, 32'h10, 32'h0, lat, rdc, wrc, bad);
    check("tmo latency", lat, 17);
    check("tmo read cycles", rdc, 16);
    check("tmo rsp_timeout", rsp_timeout, 1);
    check("tmo response", rsp_response, 2'b11);
    check("tmo rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    stall = 1'b0;
    check("tmo read dropped", avmm_read, 0);

    // 6: reset mid-READ, then a stray rdvalid in IDLE
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h04;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid read asserted", avmm_read, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst avmm_read", avmm_read, 0);
    check("mid rst cmd_ready", cmd_ready, 1);
    check("mid rst rsp_rdata", rsp_rdata, 0);
    check("mid rst rsp_response", rsp_response, 0);
    check("mid rst avmm_addr", avmm_addr, 0);
    seen = 0;
    stray_rd = 1'b1;
    @(posedge clk); #1;
    stray_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || !cmd_ready) seen++;
      @(posedge clk); #1;
    end
    check("stray rd ignored", seen, 0);
    run_cmd(1'b1, 32'h00, 32'h1234_5678, lat, rdc, wrc, bad);
    check("post-rst wr latency", lat, 3);
    check("post-rst wr response", rsp_response, 2'b00);
    run_cmd(1'b0, 32'h00, 32'h0, lat, rdc, wrc, bad);
    check("post-rst rd rdata", rsp_rdata, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
